// File: rtl/vga_scan_ctrl.sv
// 640x480@60 VGA scan timing: pixel-rate divider, scan counters, visible-window decode,
// frame pacing, and a sync/colour output pipeline matched to the game logic's rgb latency.
module vga_scan_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int RGB_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb,
    input  logic        force_blank,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        bright,
    output logic        pix_en,
    output logic        frame_tick,
    output logic [15:0] frame_count,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] H_SYNC_W    = 10'd96;
    localparam logic [9:0] H_VIS_FIRST = 10'd144;
    localparam logic [9:0] H_VIS_LAST  = 10'd783;
    localparam logic [9:0] V_LAST      = 10'd524;
    localparam logic [9:0] V_SYNC_W    = 10'd2;
    localparam logic [9:0] V_VIS_FIRST = 10'd35;
    localparam logic [9:0] V_VIS_LAST  = 10'd514;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic bright;
    } scan_sync_t;

    localparam scan_sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, bright: 1'b0};

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             line_end;
    logic             frame_end;
    scan_sync_t       scan_now;
    scan_sync_t       pipe_q [RGB_DELAY];
    scan_sync_t       pipe_tail;
    logic             vga_hsync_q;
    logic             vga_vsync_q;
    logic [11:0]      colour_q, colour_d;

    assign pix_en    = (div_q == DIV_LAST);
    assign line_end  = (hcount_q == H_LAST);
    assign frame_end = line_end && (vcount_q == V_LAST);
    assign frame_tick = pix_en && frame_end;

    assign scan_now.hsync_n = !(hcount_q < H_SYNC_W);
    assign scan_now.vsync_n = !(vcount_q < V_SYNC_W);
    assign scan_now.bright  = (hcount_q >= H_VIS_FIRST) && (hcount_q <= H_VIS_LAST) &&
                              (vcount_q >= V_VIS_FIRST) && (vcount_q <= V_VIS_LAST);

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        div_d         = div_q + 1'b1;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_count_d = frame_count_q;
        if (pix_en) begin
            div_d    = '0;
            hcount_d = line_end ? 10'd0 : hcount_q + 10'd1;
            if (line_end) begin
                vcount_d = frame_end ? 10'd0 : vcount_q + 10'd1;
            end
            if (frame_end) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_count_q <= '0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pipe_tail = pipe_q[RGB_DELAY-1];
    assign colour_d  = (pipe_tail.bright && !force_blank) ? rgb : 12'h000;

    // NOTE: the delay stages are reset individually (a few flops, not a RAM) so the pins come out
    // of reset idle instead of replaying stale sync states.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RGB_DELAY; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
            vga_hsync_q <= 1'b1;
            vga_vsync_q <= 1'b1;
            colour_q    <= 12'h000;
        end else if (pix_en) begin
            pipe_q[0] <= scan_now;
            for (int i = 1; i < RGB_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            vga_hsync_q <= pipe_tail.hsync_n;
            vga_vsync_q <= pipe_tail.vsync_n;
            colour_q    <= colour_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign bright      = scan_now.bright;
    assign frame_count = frame_count_q;
    assign vga_hsync   = vga_hsync_q;
    assign vga_vsync   = vga_vsync_q;
    assign vga_r       = colour_q[11:8];
    assign vga_g       = colour_q[7:4];
    assign vga_b       = colour_q[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl: a timing model feeds a pin scoreboard every pixel slot,
// a vector table jumps the scan to interesting regions, and hand sequences cover reset and sync widths.
module tb_vga_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int RGB_DELAY = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb = 12'hFFF;
    logic        force_blank = 1'b0;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        bright;
    logic        pix_en;
    logic        frame_tick;
    logic [15:0] frame_count;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    vga_scan_ctrl #(.CLK_DIV(CLK_DIV), .RGB_DELAY(RGB_DELAY)) dut (
        .clk        (clk),
        .reset      (reset),
        .rgb        (rgb),
        .force_blank(force_blank),
        .hcount     (hcount),
        .vcount     (vcount),
        .bright     (bright),
        .pix_en     (pix_en),
        .frame_tick (frame_tick),
        .frame_count(frame_count),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_lo_tot = 0;
    int vs_lo_tot = 0;
    int tick_tot = 0;

    // Reference timing model, advanced on the same edges the DUT uses.
    int          m_div = 0;
    int          m_h = 0;
    int          m_v = 0;
    logic [15:0] m_fc = 16'h0000;
    logic [11:0] s_rgb = 12'h000;
    logic        s_fb = 1'b0;
    logic        jump_req = 1'b0;
    logic        jump_fc_en = 1'b0;
    logic [9:0]  jump_h = 10'd0;
    logic [9:0]  jump_v = 10'd0;
    logic [15:0] jump_fc = 16'h0000;

    always @(posedge clk) begin
        if (reset) begin
            m_div <= 0;
            m_h   <= 0;
            m_v   <= 0;
            m_fc  <= 16'h0000;
        end else begin
            if (m_div == CLK_DIV - 1) begin
                m_div <= 0;
                s_rgb <= rgb;
                s_fb  <= force_blank;
                if (m_h == 799) begin
                    m_h <= 0;
                    m_v <= (m_v == 524) ? 0 : m_v + 1;
                    if (m_v == 524) m_fc <= m_fc + 16'd1;
                end else begin
                    m_h <= m_h + 1;
                end
            end else begin
                m_div <= m_div + 1;
            end
            if (jump_req) begin
                m_h <= int'(jump_h);
                m_v <= int'(jump_v);
                if (jump_fc_en) m_fc <= jump_fc;
            end
        end
    end

    typedef struct packed {
        logic hs;
        logic vs;
        logic br;
    } sb_t;

    sb_t sb [$];

    typedef struct {
        int          h0;
        int          v0;
        int          nslots;
        logic        fb;
        logic [11:0] col;
        int          exp_h;
        int          exp_v;
        int          exp_ticks;
        int          exp_fc;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, then score everything the DUT shows there.
    task automatic tick();
        logic        mp;
        logic        exp_br;
        logic [11:0] exp_col;
        sb_t         e;
        @(negedge clk);
        if (reset) begin
            sb.delete();
            for (int i = 0; i <= RGB_DELAY; i++) sb.push_back('{hs: 1'b1, vs: 1'b1, br: 1'b0});
        end else begin
            mp = (m_div == CLK_DIV - 1);
            check("pix_en", {31'd0, pix_en}, {31'd0, mp});
            check("frame_tick", {31'd0, frame_tick}, {31'd0, mp && m_h == 799 && m_v == 524});
            if (frame_tick) tick_tot++;
            if (mp) begin
                exp_br = (m_h >= 144) && (m_h <= 783) && (m_v >= 35) && (m_v <= 514);
                check("hcount", {22'd0, hcount}, m_h);
                check("vcount", {22'd0, vcount}, m_v);
                check("bright", {31'd0, bright}, {31'd0, exp_br});
                check("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
                sb.push_back('{hs: (m_h >= 96), vs: (m_v >= 2), br: exp_br});
                if (sb.size() == RGB_DELAY + 2) begin
                    e = sb.pop_front();
                    exp_col = (e.br && !s_fb) ? s_rgb : 12'h000;
                    check("vga_hsync", {31'd0, vga_hsync}, {31'd0, e.hs});
                    check("vga_vsync", {31'd0, vga_vsync}, {31'd0, e.vs});
                    check("colour", {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp_col});
                end
                if (!vga_hsync) hs_lo_tot++;
                if (!vga_vsync) vs_lo_tot++;
            end
        end
    endtask

    task automatic run_slots(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            tick();
            if (m_div == CLK_DIV - 1) seen++;
        end
        while (m_div != 0) tick();
    endtask

    // Move the scan (and optionally the frame counter) at a slot start; ends one clock later.
    task automatic jump(input int h, input int v, input logic fb, input logic [11:0] col,
                        input logic fc_en, input logic [15:0] fc);
        while (m_div != 0) tick();
        force_blank = fb;
        rgb         = col;
        jump_h      = 10'(h);
        jump_v      = 10'(v);
        jump_fc     = fc;
        jump_fc_en  = fc_en;
        jump_req    = 1'b1;
        force dut.hcount_q = jump_h;
        force dut.vcount_q = jump_v;
        if (fc_en) force dut.frame_count_q = jump_fc;
        #1;
        release dut.hcount_q;
        release dut.vcount_q;
        if (fc_en) release dut.frame_count_q;
        tick();
        jump_req   = 1'b0;
        jump_fc_en = 1'b0;
    endtask

    initial begin
        int first_pix;
        int hs0;
        int vs0;
        int tk0;

        vecs[0] = '{770, 34,  400, 1'b0, 12'hF80, 370, 35,  0, 1};
        vecs[1] = '{770, 514, 100, 1'b0, 12'hF80, 70,  515, 0, 1};
        vecs[2] = '{790, 524, 20,  1'b0, 12'hF80, 10,  0,   1, 1};
        vecs[3] = '{140, 100, 700, 1'b1, 12'hF80, 40,  101, 0, 1};
        vecs[4] = '{600, 300, 10,  1'b0, 12'h5A3, 610, 300, 0, 1};
        vecs[5] = '{798, 523, 3,   1'b0, 12'hF80, 1,   524, 0, 1};
        vecs[0].exp_fc = 0;
        vecs[1].exp_fc = 0;

        // Reset state, with a non-zero rgb present.
        repeat (3) tick();
        check("rst_hcount", {22'd0, hcount}, 32'd0);
        check("rst_vcount", {22'd0, vcount}, 32'd0);
        check("rst_bright", {31'd0, bright}, 32'd0);
        check("rst_pix_en", {31'd0, pix_en}, 32'd0);
        check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_hsync", {31'd0, vga_hsync}, 32'd1);
        check("rst_vsync", {31'd0, vga_vsync}, 32'd1);
        check("rst_colour", {20'd0, vga_r, vga_g, vga_b}, 32'd0);

        // First strobe CLK_DIV-1 clocks after release, hcount 1 after it, line wrap after 800 slots.
        rgb       = 12'hF80;
        reset     = 1'b0;
        first_pix = 0;
        for (int k = 1; k <= CLK_DIV + 4 && first_pix == 0; k++) begin
            tick();
            if (pix_en) first_pix = k;
        end
        check("first_pix_clk", first_pix, CLK_DIV - 1);
        tick();
        check("hcount_after_first", {22'd0, hcount}, 32'd1);
        run_slots(799);
        check("line_wrap_h", {22'd0, hcount}, 32'd0);
        check("line_wrap_v", {22'd0, vcount}, 32'd1);

        // Region vectors: window edges, porches, frame wrap, blanking, other colours.
        for (int i = 0; i < 6; i++) begin
            jump(vecs[i].h0, vecs[i].v0, vecs[i].fb, vecs[i].col, 1'b0, 16'h0000);
            tk0 = tick_tot;
            run_slots(vecs[i].nslots);
            check($sformatf("vec%0d_hcount", i), {22'd0, hcount}, vecs[i].exp_h);
            check($sformatf("vec%0d_vcount", i), {22'd0, vcount}, vecs[i].exp_v);
            check($sformatf("vec%0d_ticks", i), tick_tot - tk0, vecs[i].exp_ticks);
            check($sformatf("vec%0d_frame_count", i), {16'd0, frame_count}, vecs[i].exp_fc);
        end

        // Horizontal sync width over one full line of pin output.
        jump(200, 10, 1'b0, 12'hF80, 1'b0, 16'h0000);
        run_slots(RGB_DELAY + 1);
        hs0 = hs_lo_tot;
        run_slots(800);
        check("hsync_low_slots", hs_lo_tot - hs0, 96);

        // Vertical sync width across a frame boundary.
        jump(400, 523, 1'b0, 12'hF80, 1'b0, 16'h0000);
        run_slots(RGB_DELAY + 1);
        vs0 = vs_lo_tot;
        tk0 = tick_tot;
        run_slots(2800);
        check("vsync_low_slots", vs_lo_tot - vs0, 1600);
        check("vsync_window_ticks", tick_tot - tk0, 1);
        check("frame_count_two", {16'd0, frame_count}, 32'd2);

        // rgb glitches between strobes must never reach the pins.
        jump(300, 100, 1'b0, 12'hF80, 1'b0, 16'h0000);
        run_slots(RGB_DELAY + 1);
        for (int s = 0; s < 40; s++) begin
            rgb = 12'h0F0;
            do tick(); while (m_div != CLK_DIV - 1);
            rgb = 12'hF80;
            tick();
        end

        // Reset in the middle of a visible line.
        jump(400, 200, 1'b0, 12'hF80, 1'b0, 16'h0000);
        reset = 1'b1;
        tick();
        check("midrst_hcount", {22'd0, hcount}, 32'd0);
        check("midrst_vcount", {22'd0, vcount}, 32'd0);
        check("midrst_hsync", {31'd0, vga_hsync}, 32'd1);
        check("midrst_vsync", {31'd0, vga_vsync}, 32'd1);
        check("midrst_colour", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        check("midrst_frame_count", {16'd0, frame_count}, 32'd0);
        tick();
        reset = 1'b0;
        run_slots(10);
        check("midrst_resume_h", {22'd0, hcount}, 32'd10);

        // Frame counter wrap from 0xFFFF.
        jump(790, 524, 1'b0, 12'hF80, 1'b1, 16'hFFFF);
        tk0 = tick_tot;
        run_slots(20);
        check("fc_wrap_value", {16'd0, frame_count}, 32'd0);
        check("fc_wrap_ticks", tick_tot - tk0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Display-side timing and pixel output block for the 640x480@60 Hz VGA path. Generates the `hcount`/`vcount`/`bright` scan coordinates that the game logic renders from. Registers the game logic's returned `rgb` and drives the VGA pins, with sync outputs delayed by a programmable number of pixel slots so they stay aligned with pixel data. Also emits a once-per-frame tick and a frame counter for game-side pacing (map show timers, movement rate).

## Interface
Parameters:
- `CLK_DIV`, default 4: system clocks per pixel; 100 MHz in gives a 25 MHz pixel rate. Legal range 2..16.
- `RGB_DELAY`, default 1: pixel slots between coordinate issue and the `rgb` sample point. Legal range 1..4.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rgb`  in  12  pixel colour from game logic, {R[11:8], G[7:4], B[3:0]}.
- `force_blank`  in  1  when high, pin colour is forced to 0 (sync timing unaffected).
- `hcount`  out  10  horizontal scan position, 0..799.
- `vcount`  out  10  vertical scan position, 0..524.
- `bright`  out  1  current (`hcount`,`vcount`) is in the visible window.
- `pix_en`  out  1  one-`clk` strobe marking each pixel slot.
- `frame_tick`  out  1  one-`clk` pulse on the last pixel of each frame.
- `frame_count`  out  16  frames completed since reset; wraps.
- `vga_hsync`  out  1  horizontal sync, active low, delayed.
- `vga_vsync`  out  1  vertical sync, active low, delayed.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour to DAC pins.

## Operation
- **Divider.** `div` counts 0..`CLK_DIV`-1 and wraps. `pix_en` = (`div` == `CLK_DIV`-1), decoded combinationally.
- **Scan counters.** Both advance only on `clk` edges where `pix_en` = 1.
  - `hcount` steps 0→799, then wraps to 0.
  - `vcount` increments when `hcount` wraps; it steps 0→524, then wraps to 0.
- **Horizontal timing** (800 total): sync region 0..95, back porch 96..143, visible 144..783, front porch 784..799.
- **Vertical timing** (525 total): sync region 0..1, back porch 2..34, visible 35..514, front porch 515..524.
- **Decode.** Raw `hsync_n` = !(`hcount` < 96). Raw `vsync_n` = !(`vcount` < 2). `bright` = (144 ≤ `hcount` ≤ 783) && (35 ≤ `vcount` ≤ 514). All are combinational from the registered counters.
- **Frame tick and counter.**
  - `frame_tick` = `pix_en` && `hcount` == 799 && `vcount` == 524.
  - `frame_count` increments on the same edge; 0xFFFF wraps to 0x0000.
- **Output pipeline.** A shift register of depth `RGB_DELAY` carries {`hsync_n`, `vsync_n`, `bright`} and advances only on `pix_en`.
  - On each `pix_en` edge, the pins load:
    - `vga_hsync`/`vga_vsync` from the last stage;
    - `vga_r/g/b` = `rgb` if (last-stage `bright` && !`force_blank`), else 0.
  - Colour is always 0 during porches and sync, whatever `rgb` holds.
  - `rgb` is sampled only on `pix_en` edges; changes between strobes are ignored.
- **Reset.**
  - `div`, `hcount`, `vcount`, `frame_count` reset to 0.
  - All pipeline stages reset to {`hsync_n`=1, `vsync_n`=1, `bright`=0}.
  - Pins reset to `vga_hsync`=1, `vga_vsync`=1, colour 0.
  - Resulting combinational output values: `bright`=0, `pix_en`=0 (when `CLK_DIV` > 1), `frame_tick`=0.
- **Reset mid-frame.** Counters and pipeline return to their reset values on the same edge. There is no partial-line flush; the next line starts from `hcount` 0, `vcount` 0.

## Timing
- After `reset` falls, the first `pix_en` comes `CLK_DIV`-1 clocks later. After that, `pix_en` repeats every `CLK_DIV` clocks.
- `hcount`/`vcount`/`bright` are stable for a full pixel slot. Game logic has `CLK_DIV` clocks to return `rgb`, including its 1-clock ROM read.
- Coordinate change to pin update: `RGB_DELAY`+1 pixel slots for syncs. Colour lands on the same edge as its matching syncs.
- Line period = 800 × `CLK_DIV` clocks. Frame period = 420 000 × `CLK_DIV` clocks (1 680 000 at default).
- Sync pulse widths: `vga_hsync` low for 96 pixel slots, `vga_vsync` low for 2 lines (1600 slots).
- `frame_tick` is high for exactly 1 `clk` per frame and coincides with the `pix_en` that wraps both counters.
- `force_blank` takes effect at the next `pix_en` edge.

## Test plan
- **Reset release, defaults.** Expect the first `pix_en` at clk 3 and `hcount`=1 after it. After 800 `pix_en`: `hcount`=0, `vcount`=1.
- **One full frame.** Count `pix_en` = 420 000 and exactly one `frame_tick`, after which `frame_count`=1. Measure `vga_hsync` low = 96 slots per line and `vga_vsync` low = 1600 slots.
- **Bright window.** `bright` rises at (144,35), falls after (783,514), and is never high at `hcount`=143/784 or `vcount`=34/515.
- **Colour gating and alignment.** Hold `rgb`=0xF80 constantly. Pins show 0xF80 only in visible slots, 0 elsewhere. The first visible pixel appears `RGB_DELAY`+1 slots after `bright` rises. With `force_blank`=1 the pins show 0.
- **Mid-frame reset.** Pulse `reset` at `hcount`=400, `vcount`=200. On the next clk: `hcount`=`vcount`=0, `vga_hsync`=`vga_vsync`=1, colour 0, `frame_count`=0.
- **Frame counter wrap.** Force `frame_count`=0xFFFF; the next `frame_tick` gives 0x0000.
